// File: rtl/cipher_session_ctrl.sv
// Session controller for the stream_cypher core: key load, fixed warm-up, then
// round-robin sharing of the keystream between an encrypt and a decrypt requester.
module cipher_session_ctrl #(
  parameter int KEY_BYTES = 4,
  parameter int WARMUP    = 8,
  parameter int DATA_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_valid,
  input  logic [DATA_W-1:0] key_data,
  output logic              key_ready,
  input  logic              rekey,
  input  logic              ch0_valid,
  input  logic [DATA_W-1:0] ch0_data,
  output logic              ch0_ready,
  input  logic              ch1_valid,
  input  logic [DATA_W-1:0] ch1_data,
  output logic              ch1_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_ch,
  input  logic              out_ready,
  output logic              ks_load,
  output logic [DATA_W-1:0] ks_seed,
  output logic              ks_step,
  input  logic [DATA_W-1:0] ks_byte,
  output logic              sess_ready
);

  localparam int KCNT_W = $clog2(KEY_BYTES + 1);
  localparam int WCNT_W = $clog2(WARMUP + 1);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_WARM = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [KCNT_W-1:0] kcnt;
  logic [WCNT_W-1:0] wcnt;
  logic              rr;
  logic              rekey_pend;

  logic [DATA_W-1:0] out_data_p0;
  logic              out_ch_p0;
  logic              vld_p0;

  logic key_acc;
  logic last_key;
  logic last_warm;
  logic can_accept;
  logic pick0;
  logic pick1;
  logic grant_open;
  logic fire0;
  logic fire1;
  logic fire;
  logic drain_go;

  function automatic logic [DATA_W-1:0] mix(input logic [DATA_W-1:0] d,
                                            input logic [DATA_W-1:0] ks);
    return d ^ ks;
  endfunction

  assign key_acc    = (state == S_LOAD) && key_valid && !rst;
  assign last_key   = key_acc && (kcnt == KCNT_W'(KEY_BYTES - 1));
  assign last_warm  = (state == S_WARM) && (wcnt == WCNT_W'(WARMUP - 1));
  assign can_accept = !vld_p0 || out_ready;

  // rr only breaks ties; a lone requester is always the pick
  assign pick0      = ch0_valid && (!ch1_valid || !rr);
  assign pick1      = ch1_valid && (!ch0_valid || rr);
  assign grant_open = (state == S_RUN) && can_accept && !rekey_pend && !rekey && !rst;
  assign fire0      = pick0 && grant_open;
  assign fire1      = pick1 && grant_open;
  assign fire       = fire0 || fire1;
  assign drain_go   = (state == S_RUN) && rekey_pend && can_accept;

  assign ks_seed    = key_data;
  assign out_valid  = vld_p0;
  assign out_data   = out_data_p0;
  assign out_ch     = out_ch_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_LOAD:  if (last_key)  state_nxt = S_WARM;
      S_WARM:  if (last_warm) state_nxt = S_RUN;
      S_RUN:   if (drain_go)  state_nxt = S_LOAD;
      default: state_nxt = S_LOAD;
    endcase
  end

  always_comb begin
    key_ready  = 1'b0;
    ks_load    = 1'b0;
    ks_step    = 1'b0;
    ch0_ready  = 1'b0;
    ch1_ready  = 1'b0;
    sess_ready = 1'b0;
    if (!rst) begin
      case (state)
        S_LOAD: begin
          key_ready = 1'b1;
          ks_load   = key_valid;
        end
        S_WARM: ks_step = 1'b1;
        S_RUN: begin
          sess_ready = 1'b1;
          ch0_ready  = fire0;
          ch1_ready  = fire1;
          ks_step    = fire;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      kcnt       <= '0;
      wcnt       <= '0;
      rr         <= 1'b0;
      rekey_pend <= 1'b0;
    end else begin
      if (key_acc) begin
        kcnt <= last_key ? '0 : kcnt + KCNT_W'(1);
      end else if (drain_go) begin
        kcnt <= '0;
      end
      if (state == S_WARM) begin
        wcnt <= last_warm ? '0 : wcnt + WCNT_W'(1);
      end
      if (fire0) begin
        rr <= 1'b1;
      end else if (fire1) begin
        rr <= 1'b0;
      end
      if (drain_go) begin
        rekey_pend <= 1'b0;
      end else if ((state == S_RUN) && rekey) begin
        rekey_pend <= 1'b1;
      end
    end
  end

  // Stage p0: result register, one cycle after the grant
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0      <= 1'b0;
      out_data_p0 <= '0;
      out_ch_p0   <= 1'b0;
    end else if (fire) begin
      vld_p0      <= 1'b1;
      out_data_p0 <= mix(fire1 ? ch1_data : ch0_data, ks_byte);
      out_ch_p0   <= fire1;
    end else if (vld_p0 && out_ready) begin
      vld_p0      <= 1'b0;
    end
  end

endmodule

// File: doc/cipher_session_ctrl.md
# cipher_session_ctrl

Session controller and two-channel arbiter for the `stream_cypher` keystream core. It loads a key into the core and runs a fixed warm-up. It then shares the keystream between an encrypt requester (ch0) and a decrypt requester (ch1), XORing each accepted byte with the current keystream byte and stepping the core exactly once per byte. It sits between the pin-level I/O mux and the core.

## Interface
- `KEY_BYTES`, 4: key bytes per (re)key; counter width is $clog2(KEY_BYTES+1).
- `WARMUP`, 8: keystream steps discarded after key load; must be ≥1.
- `clk`  in  1  sole clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `key_valid`  in  1  key byte offered.
- `key_data`  in  8  key byte.
- `key_ready`  out  1  controller accepts key byte.
- `rekey`  in  1  single-cycle pulse requesting a new key load.
- `ch0_valid`, `ch1_valid`  in  1 each  requester byte offered (ch0 encrypt, ch1 decrypt).
- `ch0_data`, `ch1_data`  in  8 each  plaintext or ciphertext byte.
- `ch0_ready`, `ch1_ready`  out  1 each  grant; byte consumed this cycle.
- `out_valid`  out  1  result byte held.
- `out_data`  out  8  data XOR keystream.
- `out_ch`  out  1  channel that produced `out_data`.
- `out_ready`  in  1  consumer accepts result.
- `ks_load`  out  1  load `ks_seed` into core this cycle.
- `ks_seed`  out  8  key byte to core (equals `key_data`).
- `ks_step`  out  1  advance core one keystream byte.
- `ks_byte`  in  8  core's current keystream byte (combinational, valid every cycle).
- `sess_ready`  out  1  high in RUN.

## Operation
- States: LOAD, WARM, RUN.
- LOAD:
  - `key_ready`=1; key byte accepted on `key_valid&&key_ready`.
  - Each accept drives `ks_load`=1, `ks_seed`=`key_data` the same cycle, and increments `kcnt`.
  - Accept with `kcnt`==KEY_BYTES-1 → WARM, `kcnt`←0.
- WARM:
  - `ks_step`=1 every cycle; `wcnt` increments.
  - Cycle with `wcnt`==WARMUP-1 → RUN, `wcnt`←0.
  - Channel and key inputs are ignored.
- RUN arbitration:
  - `can_accept` = !`out_valid` || `out_ready`.
  - Only one valid channel → that channel is granted.
  - Both valid → channel `rr` is granted.
  - On every grant, `rr` ← other channel.
  - `chN_ready` = grant to N && `can_accept` && !`rekey_pend` && !`rekey`. Ready may depend combinationally on valid.
- On grant to N:
  - `ks_step`=1.
  - `out_data` ← `chN_data` ^ `ks_byte`; `out_ch` ← N; `out_valid` ← 1.
- Output register:
  - Cleared when `out_valid&&out_ready` and no new grant that cycle.
  - Held stable while `out_valid&&!out_ready`.
- Rekey:
  - `rekey` in RUN sets `rekey_pend`; grants stop that cycle.
  - When `rekey_pend` && (!`out_valid` || `out_ready`) → LOAD, `rekey_pend`←0, `kcnt`←0, and the output drains.
  - `rekey` in LOAD or WARM is ignored.
- At most one of `ks_load`/`ks_step` is high in any cycle. Neither is high in RUN without a grant.

## Timing
- Reset (`rst`=1 at an edge) gives:
  - State: LOAD; `kcnt`=`wcnt`=0, `rr`=0, `rekey_pend`=0.
  - Outputs: `out_valid`=0, `out_data`=0x00, `out_ch`=0.
  - Combinational outputs: `key_ready`, `ks_load`, `ks_step`, `chN_ready`, `sess_ready` forced 0 while `rst`=1.
- Reset mid-LOAD, mid-WARM or with `out_valid`=1: everything returns to the reset values above. The held output is lost and the partial key is discarded.
- Key load: KEY_BYTES accepted cycles minimum. Warm-up: exactly WARMUP cycles. `sess_ready` rises the cycle after the last warm-up step.
- Data latency: 1 cycle from grant to `out_valid`.
- Throughput: 1 byte/cycle with `out_ready` held high.
- Simultaneous drain and grant: the output register is overwritten with the new result and `out_valid` stays 1.
- `rekey` and a channel valid in the same cycle: rekey wins and there is no grant.

## Test plan
- Reset, then load key 0x01,0x02,0x03,0x04 with `key_valid` held: `ks_load` high 4 cycles with matching `ks_seed`. Then `ks_step` high exactly 8 cycles, then `sess_ready`=1.
- RUN, `ks_byte`=0x5A, ch0 offers 0x01: `ch0_ready`=1 one cycle with `ks_step`=1. Next cycle `out_valid`=1, `out_data`=0x5B, `out_ch`=0.
- Both channels valid for 4 cycles, `out_ready`=1, `rr`=0: grants go ch0,ch1,ch0,ch1, with 4 steps and 4 consecutive outputs.
- `out_valid`=1, `out_ready`=0 for 3 cycles with both channels valid: no grants, no `ks_step`, and `out_data` is stable.
- `rekey` pulse while `out_valid`=1, `out_ready`=0: no grants. After `out_ready`=1 for one cycle the block enters LOAD (`key_ready`=1, `sess_ready`=0).
- `rst` asserted on the 3rd WARM cycle: the next cycle shows LOAD with `ks_step`=0 and `kcnt`=0. A full key reload then needs 4 more accepted bytes.
